multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multi_cycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes,
// ALU/mux select codes and the bundled control-word type.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_EXEC = 4'd8,
    ADDI_WB   = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that wait on memory and are subject to the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory wait state and flags the
// cycle on which the count would reach TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Stall-cycle counter, cleared whenever the access is not stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  // This stalled cycle is the TIMEOUT-th one; a ready in the same cycle wins.
  assign expired = stall && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout and trap state.
// Optional MC_RETIRE_COUNT_EN adds a saturating retired-instruction counter.
module multi_cycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zf,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        trap
`ifdef MC_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  state_t state_r;
  ctrl_t  ctl;
  logic   stall;
  logic   expired;
  logic   unused_zf;

  // The branch decision is taken by the datapath, so zf is not consumed here.
  assign unused_zf = zf;

  assign stall = is_wait_state(state_r) && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!stall),
    .stall   (stall),
    .expired (expired)
  );

  // Controller state sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (mem_ready)    state_r <= DECODE;
          else if (expired) state_r <= TRAP;
          else              state_r <= FETCH;
        end
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state_r <= R_EXEC;
            OP_LW, OP_SW: state_r <= MEM_ADDR;
            OP_ADDI:      state_r <= ADDI_EXEC;
            OP_BEQ:       state_r <= BRANCH;
            OP_J:         state_r <= JUMP;
            default:      state_r <= TRAP;
          endcase
        end
        MEM_ADDR:  state_r <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (mem_ready)    state_r <= MEM_WB;
          else if (expired) state_r <= TRAP;
          else              state_r <= MEM_RD;
        end
        MEM_WB:    state_r <= FETCH;
        MEM_WR: begin
          if (mem_ready)    state_r <= FETCH;
          else if (expired) state_r <= TRAP;
          else              state_r <= MEM_WR;
        end
        R_EXEC:    state_r <= R_WB;
        R_WB:      state_r <= FETCH;
        ADDI_EXEC: state_r <= ADDI_WB;
        ADDI_WB:   state_r <= FETCH;
        BRANCH:    state_r <= FETCH;
        JUMP:      state_r <= FETCH;
        TRAP:      state_r <= TRAP;
        default:   state_r <= TRAP;
      endcase
    end
  end

  // Control word decode from the current state (mem_ready only in FETCH).
  always_comb begin
    ctl = '0;
    case (state_r)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.alu_op    = ALU_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REGB;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ctl = '0;
    endcase
  end

  // Write enables are held off for the whole reset cycle, whatever the state.
  assign pc_write      = ctl.pc_write      & ~rst;
  assign pc_write_cond = ctl.pc_write_cond & ~rst;
  assign ir_write      = ctl.ir_write      & ~rst;
  assign reg_write     = ctl.reg_write     & ~rst;
  assign mem_write     = ctl.mem_write     & ~rst;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;
  assign state         = state_r;
  assign trap          = (state_r == TRAP);

`ifdef MC_RETIRE_COUNT_EN
  logic retire;

  assign retire = (state_r == MEM_WB) || (state_r == R_WB) || (state_r == ADDI_WB) ||
                  (state_r == BRANCH) || (state_r == JUMP) ||
                  ((state_r == MEM_WR) && mem_ready);

  // Saturating count of instructions that completed back into FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= 32'd0;
    end else if (retire && (retired != 32'hFFFF_FFFF)) begin
      retired <= retired + 32'd1;
    end else begin
      retired <= retired;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized scoreboard bench for multi_cycle_control (TIMEOUT=4); the
// retired-counter checks compile in only with MC_RETIRE_COUNT_EN.
module tb_multi_cycle_control;
  import mc_pkg::*;

  localparam int TO   = 4;
  localparam int HOLD = 10;
  localparam logic [3:0] DC = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zf = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef MC_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  multi_cycle_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .trap(trap)
`ifdef MC_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  // One scoreboard entry: the expected per-cycle state trace of an
  // instruction (or reset pulse) plus expected per-instruction signal totals.
  typedef struct packed {
    int              n;
    logic [5:0]      op;
    bit              zf;
    bit              agg;
    bit              retires;
    int              ret0;
    logic [23:0][3:0] seq;
    logic [23:0]     mr;
    logic [23:0]     rs;
    int c_mr, c_mw, c_ir, c_pcw, c_pcwc, c_rw, c_m2r, c_rdst, c_iord, c_funct, c_br, c_jmp;
  } plan_t;

  plan_t pb;
  plan_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    ret_model = 0;
  bit    stuck;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic m);
    pb.seq[pb.n] = st;
    pb.mr[pb.n]  = m;
    pb.rs[pb.n]  = 1'b0;
    pb.n++;
  endtask

  task automatic add_rand(input logic [3:0] st);
    add(st, 1'($urandom));
  endtask

  task automatic add_trap();
    for (int i = 0; i < HOLD; i++) add_rand(TRAP);
    stuck = 1'b1;
  endtask

  // Memory wait phase: `stalls` not-ready cycles then ready, or timeout.
  task automatic add_wait(input logic [3:0] st, input int stalls, output int cycles, output bit to);
    to = (stalls >= TO);
    cycles = to ? TO : stalls + 1;
    for (int i = 0; i < stalls && i < TO; i++) add(st, 1'b0);
    if (to) add_trap();
    else add(st, 1'b1);
  endtask

  // Reference behaviour of one instruction from the instruction-level rules.
  task automatic mk_instr(input logic [5:0] op, input int fs, input int ms, input bit z);
    int c;
    bit to;
    pb = '0;
    pb.op = op; pb.zf = z; pb.agg = 1'b1;
    stuck = 1'b0;
    add_wait(FETCH, fs, c, to);
    pb.c_mr = c;
    if (!to) begin
      pb.c_ir = 1; pb.c_pcw = 1;
      add_rand(DECODE);
      case (op)
        OP_RTYPE: begin
          add_rand(R_EXEC); add_rand(R_WB);
          pb.c_rw = 1; pb.c_rdst = 1; pb.c_funct = 1; pb.retires = 1'b1;
        end
        OP_ADDI: begin
          add_rand(ADDI_EXEC); add_rand(ADDI_WB);
          pb.c_rw = 1; pb.retires = 1'b1;
        end
        OP_LW: begin
          add_rand(MEM_ADDR);
          add_wait(MEM_RD, ms, c, to);
          pb.c_mr += c; pb.c_iord = c;
          if (!to) begin
            add_rand(MEM_WB);
            pb.c_rw = 1; pb.c_m2r = 1; pb.retires = 1'b1;
          end
        end
        OP_SW: begin
          add_rand(MEM_ADDR);
          add_wait(MEM_WR, ms, c, to);
          pb.c_mw = c; pb.c_iord = c;
          pb.retires = !to;
        end
        OP_BEQ: begin
          add_rand(BRANCH);
          pb.c_pcwc = 1; pb.c_br = 1; pb.retires = 1'b1;
        end
        OP_J: begin
          add_rand(JUMP);
          pb.c_pcw = 2; pb.c_jmp = 1; pb.retires = 1'b1;
        end
        default: add_trap();
      endcase
    end
  endtask

  task automatic issue();
    pb.ret0 = ret_model;
    sbq.push_back(pb);
    for (int i = 0; i < pb.n; i++) begin
      opcode = pb.op; zf = pb.zf; mem_ready = pb.mr[i]; rst = pb.rs[i];
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    if (pb.rs != '0) ret_model = 0;
    else if (pb.retires) ret_model = (ret_model == 32'hFFFF_FFFF) ? ret_model : ret_model + 1;
  endtask

  task automatic do_rst(input logic [3:0] exp_st);
    pb = '0;
    pb.n = 1; pb.seq[0] = exp_st; pb.rs[0] = 1'b1; pb.mr[0] = 1'($urandom);
    pb.op = 6'($urandom);
    issue();
  endtask

  task automatic run(input logic [5:0] op, input int fs, input int ms, input bit z);
    mk_instr(op, fs, ms, z);
    issue();
    if (stuck) do_rst(TRAP);
  endtask

  // Monitor: pops an entry and checks it cycle by cycle, then its totals.
  plan_t cur;
  int    idx;
  bit    busy = 1'b0;
  int a_mr, a_mw, a_ir, a_pcw, a_pcwc, a_rw, a_m2r, a_rdst, a_iord, a_funct, a_br, a_jmp, a_ovl;
  logic [3:0] exp_st;

  initial begin
    forever begin
      @(negedge clk);
      if (!busy && sbq.size() > 0) begin
        cur = sbq.pop_front();
        idx = 0; busy = 1'b1;
        {a_mr, a_mw, a_ir, a_pcw, a_pcwc, a_rw, a_m2r} = '0;
        {a_rdst, a_iord, a_funct, a_br, a_jmp, a_ovl} = '0;
`ifdef MC_RETIRE_COUNT_EN
        chk("retired", int'(retired), cur.ret0);
`endif
      end
      if (busy) begin
        exp_st = cur.seq[idx];
        if (exp_st != DC) begin
          chk("state", int'(state), int'(exp_st));
          chk("trap", int'(trap), int'(exp_st == TRAP));
          if (exp_st == TRAP)
            chk("trap_outputs_zero", int'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source} != '0), 0);
        end
        if (cur.rs[idx])
          chk("write_enables_in_reset", int'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 0);
        a_mr    += int'(mem_read);
        a_mw    += int'(mem_write);
        a_ir    += int'(ir_write);
        a_pcw   += int'(pc_write);
        a_pcwc  += int'(pc_write_cond);
        a_rw    += int'(reg_write);
        a_m2r   += int'(mem_to_reg);
        a_rdst  += int'(reg_dst);
        a_iord  += int'(i_or_d);
        a_funct += int'(alu_op == ALU_FUNCT);
        a_br    += int'(pc_write_cond && pc_source == PCSRC_ALUOUT && alu_op == ALU_SUB);
        a_jmp   += int'(pc_write && pc_source == PCSRC_JUMP);
        a_ovl   += int'(mem_write && reg_write);
        idx++;
        if (idx == cur.n) begin
          busy = 1'b0;
          if (cur.agg) begin
            chk("mem_read_cycles", a_mr, cur.c_mr);
            chk("mem_write_cycles", a_mw, cur.c_mw);
            chk("ir_write_cycles", a_ir, cur.c_ir);
            chk("pc_write_cycles", a_pcw, cur.c_pcw);
            chk("pc_write_cond_cycles", a_pcwc, cur.c_pcwc);
            chk("reg_write_cycles", a_rw, cur.c_rw);
            chk("mem_to_reg_cycles", a_m2r, cur.c_m2r);
            chk("reg_dst_cycles", a_rdst, cur.c_rdst);
            chk("i_or_d_cycles", a_iord, cur.c_iord);
            chk("alu_funct_cycles", a_funct, cur.c_funct);
            chk("branch_select_cycles", a_br, cur.c_br);
            chk("jump_select_cycles", a_jmp, cur.c_jmp);
            chk("memwrite_regwrite_overlap", a_ovl, 0);
          end
        end
      end
    end
  end

  logic [5:0] ops [6];
  logic [5:0] op;

  initial begin
    ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    @(posedge clk);
    #1;
    do_rst(DC);
    do_rst(FETCH);
    run(OP_RTYPE, 0, 0, 1'b0);
    run(OP_LW, 0, 3, 1'b0);
    run(OP_BEQ, 0, 0, 1'b0);
    run(OP_BEQ, 0, 0, 1'b1);
    run(OP_SW, 1, 2, 1'b0);
    run(OP_ADDI, 2, 0, 1'b1);
    run(OP_J, 0, 0, 1'b0);
    run(6'b111111, 0, 0, 1'b0);
    run(OP_RTYPE, TO - 1, 0, 1'b0);
    run(OP_RTYPE, TO, 0, 1'b0);
    run(OP_LW, 0, TO, 1'b0);
    run(OP_SW, 0, TO - 1, 1'b0);
    // Retire sequence, then a reset in the middle of a store.
    do_rst(FETCH);
    run(OP_J, 0, 0, 1'b0);
    run(OP_SW, 0, 1, 1'b0);
    run(OP_ADDI, 0, 0, 1'b0);
    mk_instr(OP_SW, 0, 3, 1'b0);
    pb.n = 5;
    pb.rs[4] = 1'b1;
    pb.agg = 1'b0;
    pb.retires = 1'b0;
    issue();
    run(OP_RTYPE, 0, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 9) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run(op, ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2),
          1'($urandom));
    end
    run(OP_J, 0, 0, 1'b0);
    do_rst(FETCH);
    for (int i = 0; i < 50 && (busy || sbq.size() > 0); i++) @(posedge clk);
    if (busy || sbq.size() > 0) chk("scoreboard_drain", sbq.size() + int'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
